// File: rtl/window_alignment_pkg.sv
// Geometry shared by the window alignment write stream and its consumers.
package pkg_windowAlignment;
   localparam int INDEX_WIDTH = 3;
   localparam int WORDS       = 2;
   localparam int WORD_SIZE   = 8;
endpackage

// File: rtl/window_loader_pkg.sv
// Shared types and constants for window_loader (state encoding, counter widths, address helper).
package pkg_windowLoader;
   import pkg_windowAlignment::*;

   typedef enum logic {
      FILL   = 1'b0,
      LOCKED = 1'b1
   } wl_state_e;

   localparam int ROWS_DONE_W = INDEX_WIDTH + 1;
   localparam int WORD_SEL_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int FLAT_W      = 2 * INDEX_WIDTH;

   // Row-major block index; wide enough for any in-range (row, block) pair.
   function automatic logic [FLAT_W-1:0] flat_index(input logic [INDEX_WIDTH-1:0] y,
                                                     input logic [INDEX_WIDTH-1:0] b,
                                                     input int                     blocks);
      return FLAT_W'(y) * FLAT_W'(blocks) + FLAT_W'(b);
   endfunction
endpackage

// File: rtl/intf_windowAlignment.sv
// Window alignment write stream: one block (WORDS lanes) per beat, no back-pressure.
interface intf_windowAlignment;
   import pkg_windowAlignment::*;

   logic [INDEX_WIDTH-1:0]          waddrY;
   logic [INDEX_WIDTH-1:0]          waddrBlock;
   logic [WORDS-1:0][WORD_SIZE-1:0] wdata;
   logic                            we;

   modport source (output waddrY, output waddrBlock, output wdata, output we);
   modport sink   (input  waddrY, input  waddrBlock, input  wdata, input  we);
endinterface

// File: rtl/window_loader_bank.sv
// One word lane of window storage: read-first RAM with a registered, resettable read port.
module window_loader_bank #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             re_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // Storage is deliberately not reset; validity is tracked by the loader's bitmap.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end else begin
         rdata_q <= '0;
      end
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/window_loader.sv
// Collects a ROWS x BLOCKS window from the alignment stream and locks it until released.
// Optional saturating drop counter on overrun_count: define WINDOW_LOADER_OVERRUN_CNT_EN.
module window_loader
   import pkg_windowAlignment::*, pkg_windowLoader::*;
#(
   parameter int ROWS   = 2**pkg_windowAlignment::INDEX_WIDTH,
   parameter int BLOCKS = 2**pkg_windowAlignment::INDEX_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   intf_windowAlignment.sink      wr,
   input  logic [INDEX_WIDTH-1:0] rd_row,
   input  logic [INDEX_WIDTH-1:0] rd_block,
   input  logic [WORD_SEL_W-1:0]  rd_word,
   output logic [WORD_SIZE-1:0]   rd_data,
   output logic                   window_ready,
   input  logic                   window_release,
   output logic [ROWS_DONE_W-1:0] rows_done,
   output logic                   err_range,
   output logic                   err_overrun,
   output logic [15:0]            overrun_count
);
   localparam int DEPTH = ROWS * BLOCKS;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [INDEX_WIDTH:0] ROWS_L   = (INDEX_WIDTH+1)'(ROWS);
   localparam logic [INDEX_WIDTH:0] BLOCKS_L = (INDEX_WIDTH+1)'(BLOCKS);

   wl_state_e              state_q;
   logic [DEPTH-1:0]       valid_q, valid_d, valid_set_s;
   logic [ROWS_DONE_W-1:0] rows_done_q, rows_done_d;
   logic                   ready_q, err_range_q, err_overrun_q;
   logic [WORD_SEL_W-1:0]  rd_word_q;
   logic                   wr_in_range_s, rd_in_range_s, release_s;
   logic                   wr_accept_s, range_drop_s, overrun_drop_s, full_s;
   logic [AW-1:0]          wr_addr_s, rd_addr_s;
   logic [WORD_SIZE-1:0]   lane_rdata_s [WORDS];

   // A release turns the locked window back into an open one within the same cycle,
   // so a concurrent write lands as the first block of the new window.
   always_comb begin
      wr_in_range_s  = ({1'b0, wr.waddrY} < ROWS_L) && ({1'b0, wr.waddrBlock} < BLOCKS_L);
      rd_in_range_s  = ({1'b0, rd_row} < ROWS_L) && ({1'b0, rd_block} < BLOCKS_L);
      wr_addr_s      = AW'(flat_index(wr.waddrY, wr.waddrBlock, BLOCKS));
      rd_addr_s      = AW'(flat_index(rd_row, rd_block, BLOCKS));
      release_s      = (state_q == LOCKED) && window_release;
      overrun_drop_s = wr.we && (state_q == LOCKED) && !window_release;
      range_drop_s   = wr.we && !wr_in_range_s && !overrun_drop_s;
      wr_accept_s    = wr.we && wr_in_range_s && !overrun_drop_s;
   end

   always_comb begin
      valid_set_s = '0;
      if (wr_accept_s) begin
         valid_set_s[wr_addr_s] = 1'b1;
      end else begin
         valid_set_s = '0;
      end
      valid_d     = (release_s ? {DEPTH{1'b0}} : valid_q) | valid_set_s;
      full_s      = &valid_d;
      rows_done_d = '0;
      for (int r = 0; r < ROWS; r++) begin
         if (&valid_d[r*BLOCKS +: BLOCKS]) begin
            rows_done_d = rows_done_d + ROWS_DONE_W'(1);
         end else begin
            rows_done_d = rows_done_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= FILL;
         valid_q       <= '0;
         rows_done_q   <= '0;
         ready_q       <= 1'b0;
         err_range_q   <= 1'b0;
         err_overrun_q <= 1'b0;
         rd_word_q     <= '0;
      end else begin
         case (state_q)
            FILL:    state_q <= full_s ? LOCKED : FILL;
            LOCKED:  state_q <= (release_s && !full_s) ? FILL : LOCKED;
            default: state_q <= FILL;
         endcase
         valid_q       <= valid_d;
         rows_done_q   <= rows_done_d;
         ready_q       <= full_s;
         err_range_q   <= err_range_q | range_drop_s;
         err_overrun_q <= err_overrun_q | overrun_drop_s;
         rd_word_q     <= rd_word;
      end
   end

   for (genvar l = 0; l < WORDS; l++) begin : g_lane
      window_loader_bank #(
         .WIDTH (WORD_SIZE),
         .DEPTH (DEPTH),
         .AW    (AW)
      ) u_bank (
         .clk_i   (clk),
         .rst_n_i (rst_n),
         .we_i    (wr_accept_s),
         .waddr_i (wr_addr_s),
         .wdata_i (wr.wdata[l]),
         .re_i    (rd_in_range_s),
         .raddr_i (rd_addr_s),
         .rdata_o (lane_rdata_s[l])
      );
   end

`ifdef WINDOW_LOADER_OVERRUN_CNT_EN
   logic [15:0] overrun_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         overrun_cnt_q <= 16'h0000;
      end else if (overrun_drop_s && (overrun_cnt_q != 16'hFFFF)) begin
         overrun_cnt_q <= overrun_cnt_q + 16'h0001;
      end else begin
         overrun_cnt_q <= overrun_cnt_q;
      end
   end

   assign overrun_count = overrun_cnt_q;
`else
   assign overrun_count = 16'h0000;
`endif

   assign rd_data      = lane_rdata_s[rd_word_q];
   assign window_ready = ready_q;
   assign rows_done    = rows_done_q;
   assign err_range    = err_range_q;
   assign err_overrun  = err_overrun_q;
endmodule

// File: tb/tb_window_loader.sv
// Directed self-checking bench for window_loader with ROWS=4, BLOCKS=2 (WORDS=2, WORD_SIZE=8).
module tb_window_loader;
   import pkg_windowAlignment::*;

   localparam int ROWS   = 4;
   localparam int BLOCKS = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] rd_row, rd_block;
   logic       rd_word;
   logic [7:0] rd_data;
   logic       window_ready, window_release;
   logic [3:0] rows_done;
   logic       err_range, err_overrun;
   logic [15:0] overrun_count;
   logic [15:0] exp_ovr;
   int         n_tests = 0;
   int         n_fail  = 0;

   intf_windowAlignment wr_if ();

   window_loader #(.ROWS(ROWS), .BLOCKS(BLOCKS)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .wr             (wr_if),
      .rd_row         (rd_row),
      .rd_block       (rd_block),
      .rd_word        (rd_word),
      .rd_data        (rd_data),
      .window_ready   (window_ready),
      .window_release (window_release),
      .rows_done      (rows_done),
      .err_range      (err_range),
      .err_overrun    (err_overrun),
      .overrun_count  (overrun_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Lane-0 byte of block (y,b) in fill generation gen; lane 1 carries its complement.
   function automatic logic [7:0] pat(input int y, input int b, input int gen);
      return 8'((gen << 6) | (y << 4) | b);
   endfunction

   task automatic wr_blk(input int y, input int b, input logic [7:0] d);
      wr_if.waddrY     = 3'(y);
      wr_if.waddrBlock = 3'(b);
      wr_if.wdata      = {~d, d};
      wr_if.we         = 1'b1;
      tick();
      wr_if.we         = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input int y, input int b, input int w, input logic [7:0] d);
      logic [7:0] e;
      e        = (w == 0) ? d : ~d;
      rd_row   = 3'(y);
      rd_block = 3'(b);
      rd_word  = 1'(w);
      tick();
      chk(tag, 32'(rd_data), 32'(e));
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_ready"},   32'(window_ready),  32'd0);
      chk({tag, "_rows"},    32'(rows_done),     32'd0);
      chk({tag, "_erange"},  32'(err_range),     32'd0);
      chk({tag, "_eover"},   32'(err_overrun),   32'd0);
      chk({tag, "_ovr_cnt"}, 32'(overrun_count), 32'd0);
      chk({tag, "_rd_data"}, 32'(rd_data),       32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      window_release = 1'b0;
      wr_if.we = 1'b0;
      wr_if.waddrY = 3'd0;
      wr_if.waddrBlock = 3'd0;
      wr_if.wdata = 16'h0000;
      rd_row = 3'd0;
      rd_block = 3'd0;
      rd_word = 1'b0;
`ifdef WINDOW_LOADER_OVERRUN_CNT_EN
      exp_ovr = 16'd3;
`else
      exp_ovr = 16'd0;
`endif
      tick();
      tick();
      chk_reset_state("reset");
      rst_n = 1'b1;
      tick();

      // Rewrite of one block: last data wins, no error raised.
      wr_blk(1, 1, 8'h11);
      wr_blk(1, 1, 8'h22);
      chk("rewrite_erange", 32'(err_range), 32'd0);
      chk("rewrite_eover", 32'(err_overrun), 32'd0);
      rd_chk("rewrite_rd_w0", 1, 1, 0, 8'h22);
      rd_chk("rewrite_rd_w1", 1, 1, 1, 8'h22);

      // rd_data must hold the registered value after the address moves.
      rd_row = 3'd1; rd_block = 3'd1; rd_word = 1'b0;
      tick();
      rd_row = 3'd0; rd_block = 3'd0;
      #1;
      chk("rd_registered", 32'(rd_data), 32'h22);

      wr_blk(5, 0, 8'hEE);
      chk("oor_row_erange", 32'(err_range), 32'd1);
      chk("oor_row_eover", 32'(err_overrun), 32'd0);
      chk("oor_row_ready", 32'(window_ready), 32'd0);
      wr_blk(3, 2, 8'hEE);
      chk("oor_blk_ready", 32'(window_ready), 32'd0);

      for (int i = 0; i < 8; i++) begin
         wr_blk(i / 2, i % 2, pat(i / 2, i % 2, 0));
         if (i == 1) begin
            tick();
            chk("fill0_rows_row0", 32'(rows_done), 32'd1);
         end
         if (i == 6) chk("fill0_ready_before_last", 32'(window_ready), 32'd0);
         if (i == 7) chk("fill0_ready_latency", 32'(window_ready), 32'd1);
      end
      tick();
      chk("fill0_rows_full", 32'(rows_done), 32'd4);
      for (int i = 0; i < 8; i++) begin
         for (int w = 0; w < 2; w++) begin
            rd_chk("fill0_rd", i / 2, i % 2, w, pat(i / 2, i % 2, 0));
         end
      end

      for (int k = 0; k < 3; k++) wr_blk(0, 0, 8'hA5);
      chk("overrun_flag", 32'(err_overrun), 32'd1);
      chk("overrun_count", 32'(overrun_count), 32'(exp_ovr));
      chk("overrun_still_ready", 32'(window_ready), 32'd1);
      rd_chk("overrun_keep_w0", 0, 0, 0, pat(0, 0, 0));
      rd_chk("overrun_keep_w1", 0, 0, 1, pat(0, 0, 0));

      // Release together with a write to (0,0).
      window_release = 1'b1;
      wr_blk(0, 0, pat(0, 0, 1));
      window_release = 1'b0;
      chk("rel_wr_ready", 32'(window_ready), 32'd0);
      chk("rel_wr_ovr_cnt", 32'(overrun_count), 32'(exp_ovr));
      chk("rel_keeps_erange", 32'(err_range), 32'd1);
      chk("rel_keeps_eover", 32'(err_overrun), 32'd1);
      tick();
      chk("rel_wr_rows", 32'(rows_done), 32'd0);
      rd_chk("rel_wr_data", 0, 0, 0, pat(0, 0, 1));

      // Refill the other 7 blocks; a release pulse in FILL must change nothing.
      for (int i = 1; i < 8; i++) begin
         wr_blk(i / 2, i % 2, pat(i / 2, i % 2, 1));
         if (i == 3) begin
            window_release = 1'b1;
            tick();
            window_release = 1'b0;
         end
         if (i == 6) chk("fill1_ready_before_last", 32'(window_ready), 32'd0);
         if (i == 7) chk("fill1_ready", 32'(window_ready), 32'd1);
      end
      tick();
      chk("fill1_rows", 32'(rows_done), 32'd4);
      chk("fill1_ovr_cnt", 32'(overrun_count), 32'(exp_ovr));

      window_release = 1'b1;
      tick();
      window_release = 1'b0;
      chk("rel2_ready", 32'(window_ready), 32'd0);
      tick();
      chk("rel2_rows", 32'(rows_done), 32'd0);

      // Partial fill, then a one-cycle reset discards progress but not storage.
      for (int i = 0; i < 5; i++) wr_blk(i / 2, i % 2, pat(i / 2, i % 2, 2));
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk_reset_state("midrst");
      rd_chk("midrst_stale_data", 0, 0, 0, pat(0, 0, 2));

      for (int i = 5; i < 8; i++) wr_blk(i / 2, i % 2, pat(i / 2, i % 2, 3));
      tick();
      chk("post_rows_partial", 32'(rows_done), 32'd1);
      chk("post_ready_partial", 32'(window_ready), 32'd0);
      for (int i = 0; i < 5; i++) begin
         wr_blk(i / 2, i % 2, pat(i / 2, i % 2, 3));
         if (i == 3) chk("post_ready_before_last", 32'(window_ready), 32'd0);
         if (i == 4) chk("post_ready", 32'(window_ready), 32'd1);
      end
      tick();
      chk("post_rows_full", 32'(rows_done), 32'd4);
      rd_chk("post_rd", 2, 0, 1, pat(2, 0, 3));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
